// File: rtl/serial_word_tx.sv
// Frame transmitter: start bit, n data bits LSB first, optional even parity (PARITY_EN), stop bit.
// Each bit is held CLKS_PER_BIT enabled cycles; ready only in IDLE, so words offered while busy are ignored.
module serial_word_tx #(
  parameter int n            = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] PI,
  input  logic         valid,
  output logic         ready,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(n - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [n-1:0]   sr_q, sr_d;
`ifdef PARITY_EN
  logic           par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (cyc_q == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            sr_d    = PI;
            cyc_d   = '0;
            state_d = S_START;
`ifdef PARITY_EN
            par_d   = ^PI;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc_d   = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc_d = '0;
            sr_d  = sr_q >> 1;
            if (bit_q == BIT_LAST) begin
`ifdef PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cyc_d   = '0;
            state_d = S_STOP;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cyc_d   = '0;
            state_d = S_IDLE;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so en=0 freezes them along with the state.
  always_comb begin
    sout = 1'b1;
    case (state_q)
      S_START:  sout = 1'b0;
      S_DATA:   sout = sr_q[0];
`ifdef PARITY_EN
      S_PARITY: sout = par_q;
`endif
      default:  sout = 1'b1;
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: frame-position model checked every cycle plus directed literal checks.
module tb_serial_word_tx;

  localparam int N   = 4;
  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NB = N + 3;
`else
  localparam int NB = N + 2;
`endif
  localparam int FL = NB * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [N-1:0] PI = '0;
  logic         valid = 1'b0;
  logic         ready, sout, busy, done;

  int tests = 0;
  int fails = 0;

  serial_word_tx #(.n(N), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .en(en), .PI(PI), .valid(valid),
    .ready(ready), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just a position counter over the bit list {start, word LSB first, [parity], stop}.
  bit           m_act = 1'b0;
  int           m_pos = 0;
  logic [N-1:0] m_word = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      m_pos = 0;
    end else if (en) begin
      if (!m_act) begin
        if (valid) begin
          m_act  = 1'b1;
          m_pos  = 0;
          m_word = PI;
        end
      end else if (m_pos == FL - 1) begin
        m_act = 1'b0;
      end else begin
        m_pos++;
      end
    end
  end

  function automatic int model_bit(input logic [N-1:0] w, input int idx);
    if (idx == 0) return 0;
    if (idx <= N) return int'(w[idx-1]);
    if (idx == NB - 1) return 1;
    return int'(^w);
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_act) begin
      check("model_sout", int'(sout), model_bit(m_word, m_pos / CPB));
      check("model_done", int'(done), int'(m_pos == FL - 1));
      check("model_busy", int'(busy), 1);
      check("model_ready", int'(ready), 0);
    end else begin
      check("model_sout", int'(sout), 1);
      check("model_done", int'(done), 0);
      check("model_busy", int'(busy), 0);
      check("model_ready", int'(ready), 1);
    end
  end

  int   done_at, n_done, busy_cyc;
  logic sw [0:63];
  logic rw [0:63];

  // mode 0 plain, 1 valid/PI churn mid-frame, 2 en low 3 cycles in START, 3 reset in DATA bit 2
  task automatic run_frame(input logic [N-1:0] w, input int mode);
    @(negedge clk);
    PI = w;
    valid = 1'b1;
    done_at = 0;
    n_done = 0;
    busy_cyc = 0;
    for (int k = 1; k <= FL + 10; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      sw[k] = sout;
      rw[k] = ready;
      if (busy) busy_cyc++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
      if (mode == 1 && k == 5) begin valid = 1'b1; PI = '0; end
      if (mode == 1 && k == 7) valid = 1'b0;
      if (mode == 2 && k == 2) en = 1'b0;
      if (mode == 2 && k == 5) en = 1'b1;
      if (mode == 3 && k == 14) begin rst = 1'b1; break; end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_sout", int'(sout), 1);
    check("reset_ready", int'(ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1011: levels 0,1,1,0,1,(1),1 each 4 cycles
    run_frame(4'b1011, 0);
    check("f1_start", int'(sw[1]), 0);
    check("f1_start_end", int'(sw[4]), 0);
    check("f1_bit0", int'(sw[5]), 1);
    check("f1_bit1", int'(sw[9]), 1);
    check("f1_bit2", int'(sw[13]), 0);
    check("f1_bit2_end", int'(sw[16]), 0);
    check("f1_bit3", int'(sw[17]), 1);
    check("f1_stop", int'(sw[FL]), 1);
    check("f1_done_at", done_at, FL);
    check("f1_ndone", n_done, 1);
    check("f1_busy_len", busy_cyc, FL);
    check("f1_ready_last", int'(rw[FL]), 0);
    check("f1_ready_after", int'(rw[FL+1]), 1);

    // Same frame with valid/PI churn while busy
    run_frame(4'b1011, 1);
    check("f2_bit2", int'(sw[13]), 0);
    check("f2_bit3", int'(sw[17]), 1);
    check("f2_done_at", done_at, FL);
    check("f2_ndone", n_done, 1);

    // Back-to-back: valid held high, one idle cycle between frames
    begin
      int dn = 0, gap = 0, k = 0;
      @(negedge clk);
      PI = 4'b0101;
      valid = 1'b1;
      while (dn < 2 && k < 3 * FL) begin
        @(negedge clk);
        k++;
        if (dn == 1 && !busy) gap++;
        if (done) begin
          dn++;
          if (dn == 2) valid = 1'b0;
        end
      end
      check("b2b_frames", dn, 2);
      check("b2b_gap", gap, 1);
      check("b2b_total", k, 2 * FL + 1);
    end
    repeat (2) @(negedge clk);

    // Reset during DATA bit 2, then a clean 1111 frame
    run_frame(4'b1010, 3);
    @(negedge clk);
    check("rst_sout", int'(sout), 1);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(4'b1111, 0);
    check("f4_bit0", int'(sw[5]), 1);
    check("f4_bit3", int'(sw[20]), 1);
    check("f4_done_at", done_at, FL);
    check("f4_ndone", n_done, 1);

    // en low 3 cycles during START stretches start bit to 7 cycles
    run_frame(4'b0001, 2);
    begin
      int lo = 0;
      for (int k = 1; k <= 20; k++) begin
        if (sw[k] != 1'b0) break;
        lo++;
      end
      check("f5_start_len", lo, 7);
    end
    check("f5_bit0", int'(sw[8]), 1);
    check("f5_bit0_end", int'(sw[11]), 1);
    check("f5_bit1", int'(sw[12]), 0);
    check("f5_busy_len", busy_cyc, FL + 3);
    check("f5_done_at", done_at, FL + 3);

`ifdef PARITY_EN
    // 0111: levels 0,1,1,1,0,1(parity),1
    run_frame(4'b0111, 0);
    check("f6_bit3", int'(sw[17]), 0);
    check("f6_parity", int'(sw[21]), 1);
    check("f6_parity_end", int'(sw[24]), 1);
    check("f6_stop", int'(sw[25]), 1);
    check("f6_done_at", done_at, 28);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
